// File: rtl/one_hot_seq_checker.sv
// Receive-side monitor for a 4-state one-hot sequencer (0001->0010->0100->1000->0001).
// Decodes the sampled state, checks one-hot legality and successor order,
// acquires/reports lock and keeps rotation and error counters.
module one_hot_seq_checker #(
    parameter int LOCK_CNT = 3,   // consecutive correct transitions needed to lock (1..15)
    parameter int CNT_W    = 8    // width of wrap_count / err_count
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [3:0]       state_in,
    output logic [1:0]       dec_out,
    output logic             onehot_err,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } fsm_t;

    localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fsm_t             state_reg, state_next;
    logic [3:0]       prev_reg, prev_next;
    logic             have_prev_reg, have_prev_next;
    logic [3:0]       streak_reg, streak_next;
    logic [1:0]       dec_reg, dec_next;
    logic             onehot_err_reg, onehot_err_next;
    logic             seq_err_reg, seq_err_next;
    logic [CNT_W-1:0] wrap_reg, wrap_next;
    logic [CNT_W-1:0] err_reg, err_next;

    // only_bit[i] is set when the sample is exactly the one-hot code for index i
    logic [3:0] only_bit;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_only
            assign only_bit[gi] = (state_in == (4'b0001 << gi));
        end
    endgenerate

    logic       legal;
    logic [1:0] sample_idx;
    logic [3:0] successor;
    logic       is_succ;
    logic [3:0] streak_inc;

    assign legal      = |only_bit;
    assign sample_idx = {only_bit[3] | only_bit[2], only_bit[3] | only_bit[1]};
    assign successor  = {prev_reg[2:0], prev_reg[3]};
    assign is_succ    = have_prev_reg && legal && (state_in == successor);
    assign streak_inc = streak_reg + 4'd1;

    // State and output registers; reset clears everything at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= SEARCH;
            prev_reg       <= 4'b0000;
            have_prev_reg  <= 1'b0;
            streak_reg     <= 4'd0;
            dec_reg        <= 2'd0;
            onehot_err_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            wrap_reg       <= '0;
            err_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            have_prev_reg  <= have_prev_next;
            streak_reg     <= streak_next;
            dec_reg        <= dec_next;
            onehot_err_reg <= onehot_err_next;
            seq_err_reg    <= seq_err_next;
            wrap_reg       <= wrap_next;
            err_reg        <= err_next;
        end
    end

    // Next-state evaluation of one valid sample; invalid cycles hold and clear pulses
    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        have_prev_next  = have_prev_reg;
        streak_next     = streak_reg;
        dec_next        = dec_reg;
        onehot_err_next = 1'b0;
        seq_err_next    = 1'b0;
        wrap_next       = wrap_reg;
        err_next        = err_reg;

        if (in_valid) begin
            if (!legal) begin
                // Illegal code: forget history, dec_out keeps last legal index
                onehot_err_next = 1'b1;
                have_prev_next  = 1'b0;
                streak_next     = 4'd0;
                state_next      = SEARCH;
            end else begin
                prev_next      = state_in;
                have_prev_next = 1'b1;
                dec_next       = sample_idx;
                case (state_reg)
                    SEARCH: begin
                        if (is_succ) begin
                            if (streak_inc == LOCK_V) begin
                                state_next  = LOCKED;
                                streak_next = 4'd0;
                            end else begin
                                streak_next = streak_inc;
                            end
                        end else begin
                            streak_next = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (is_succ) begin
                            // 1000 -> 0001 closes one full rotation
                            if (prev_reg == 4'b1000) begin
                                wrap_next = wrap_reg + CNT_ONE;
                            end
                        end else begin
                            seq_err_next = 1'b1;
                            state_next   = SEARCH;
                            streak_next  = 4'd0;
                        end
                    end
                    default: state_next = SEARCH;
                endcase
            end
        end

        if ((onehot_err_next || seq_err_next) && (err_reg != CNT_MAX)) begin
            err_next = err_reg + CNT_ONE;
        end
    end

    assign dec_out    = dec_reg;
    assign onehot_err = onehot_err_reg;
    assign seq_err    = seq_err_reg;
    assign locked     = (state_reg == LOCKED);
    assign wrap_count = wrap_reg;
    assign err_count  = err_reg;

endmodule
